// File: rtl/serial_signed_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, one bit per clock,
// using a single full-adder cell (a + ~b + 1) and a carry flop.
// Optional build macro: SERIAL_SUB_SATURATE_EN clamps diff on signed overflow.
module serial_signed_subtractor #(
    parameter int unsigned N = 8
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                start,
    input  logic signed [N-1:0] a,
    input  logic signed [N-1:0] b,
    output logic                ready,
    output logic                busy,
    output logic                done,
    output logic signed [N-1:0] diff,
    output logic                overflow
);

    localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);
`ifdef SERIAL_SUB_SATURATE_EN
    localparam logic [N-1:0] SAT_POS = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] SAT_NEG = {1'b1, {(N-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_a;
    logic [N-1:0]    r_b;
    logic [N-1:0]    r_res;
    logic [CW-1:0]   r_cnt;
    logic            r_carry;
    logic            w_accept;
    logic            w_last;
    logic            w_sum;
    logic            w_cout;
    logic            w_ovf;
    logic [N-1:0]    w_res_nxt;
    logic [N-1:0]    w_diff_nxt;

    // Next-state decode plus the full-adder cell and final-result formation
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        w_sum       = r_a[0] ^ r_b[0] ^ r_carry;
        w_cout      = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
        w_res_nxt   = {w_sum, r_res[N-1:1]};
        // At the last step r_carry is the MSB carry-in and w_cout the MSB carry-out
        w_ovf       = r_carry ^ w_cout;
        w_diff_nxt  = w_res_nxt;
`ifdef SERIAL_SUB_SATURATE_EN
        // r_a[0] holds the sign of the original minuend at the last step
        if (w_ovf) begin
            w_diff_nxt = r_a[0] ? SAT_NEG : SAT_POS;
        end
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == LAST_STEP) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register with registered handshake outputs decoded from next state
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            ready   <= (w_state_nxt == IDLE);
            busy    <= (w_state_nxt == SHIFT);
            done    <= (w_state_nxt == DONE);
        end
    end

    // Operand shifters, carry flop, step counter and shadow result
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= ~b;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b1;
        end else if (r_state == SHIFT) begin
            r_a     <= {1'b0, r_a[N-1:1]};
            r_b     <= {1'b0, r_b[N-1:1]};
            r_res   <= w_res_nxt;
            r_cnt   <= r_cnt + CW'(1);
            r_carry <= w_cout;
        end
    end

    // Visible result only loads on the final bit-step, so it holds through later ops
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            diff     <= '0;
            overflow <= 1'b0;
        end else if (w_last) begin
            diff     <= w_diff_nxt;
            overflow <= w_ovf;
        end
    end

endmodule
